// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: opcode/funct7 values that
// select M ops, the eight M func3 codes, the FSM state type and signedness decoders.
package ex_mdu_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_M      = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } mdu_state_e;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic op1_is_signed(input logic [2:0] func3);
    return (func3 == INST_MULH) || (func3 == INST_MULHSU) ||
           (func3 == INST_DIV)  || (func3 == INST_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM only
  function automatic logic op2_is_signed(input logic [2:0] func3);
    return (func3 == INST_MULH) || (func3 == INST_DIV) || (func3 == INST_REM);
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// Decode/ctrl-side handshake and writeback bundle of the multiply/divide unit.
interface ex_mdu_if #(
  parameter int unsigned XLEN = 32
);

  logic            start_i;
  logic [2:0]      func3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            hold_flag_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            reg_wen_o;
  logic            busy_o;

  // Pipeline side: issues ops and consumes the writeback
  modport master (
    output start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  hold_flag_o, rd_addr_o, rd_data_o, reg_wen_o, busy_o
  );

  // Unit side
  modport slave (
    input  start_i, func3_i, op1_i, op2_i, rd_addr_i, flush_i,
    output hold_flag_o, rd_addr_o, rd_data_o, reg_wen_o, busy_o
  );

endinterface

// File: rtl/mdu_div_step.sv
// One iteration of restoring division: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module mdu_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            dividend_bit_i,
  output logic [XLEN:0]   rem_o,
  output logic            quo_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Trial subtraction; a set top remainder bit means the shifted value cannot be below
  // the divisor even though that bit falls off the XLEN+1-bit window.
  always_comb begin
    shifted   = {rem_i[XLEN-1:0], dividend_bit_i};
    diff      = shifted - {1'b0, divisor_i};
    quo_bit_o = rem_i[XLEN] | (shifted >= {1'b0, divisor_i});
    rem_o     = quo_bit_o ? diff : shifted;
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative radix-2 RV32M multiply/divide unit. Stalls the pipeline while an op runs
// and presents a one-cycle register writeback when it finishes.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  ex_mdu_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  mdu_state_e        state_q;
  logic [2:0]        func3_q;
  logic [4:0]        rd_q;
  logic              neg1_q;
  logic              neg2_q;
  logic              special_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   opb_q;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;   // product accumulator; low half starts as the multiplier
  logic [XLEN:0]     rem_q;
  logic [XLEN-1:0]   quo_q;   // dividend bits shift out as quotient bits shift in
  logic              wen_q;
  logic [4:0]        rd_addr_q;
  logic [XLEN-1:0]   rd_data_q;

  logic              op1_neg;
  logic              op2_neg;
  logic [XLEN-1:0]   op1_mag;
  logic [XLEN-1:0]   op2_mag;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   mul_add;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     step_rem;
  logic              step_bit;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  // Operand magnitudes and special-divide detection for the op being issued
  always_comb begin
    op1_neg  = op1_is_signed(bus.func3_i) & bus.op1_i[XLEN-1];
    op2_neg  = op2_is_signed(bus.func3_i) & bus.op2_i[XLEN-1];
    op1_mag  = op1_neg ? -bus.op1_i : bus.op1_i;
    op2_mag  = op2_neg ? -bus.op2_i : bus.op2_i;
    div_zero = bus.func3_i[2] & (bus.op2_i == '0);
    div_ovf  = ((bus.func3_i == INST_DIV) || (bus.func3_i == INST_REM)) &&
               (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op2_i);
  end

  // Shift-add: conditionally add the multiplicand into the high half
  always_comb begin
    mul_add = acc_q[0] ? opb_q : '0;
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};
  end

  mdu_div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem_i          (rem_q),
    .divisor_i      (opb_q),
    .dividend_bit_i (quo_q[XLEN-1]),
    .rem_o          (step_rem),
    .quo_bit_o      (step_bit)
  );

  // Sign correction and result select; special divides bypass correction
  always_comb begin
    prod_fix = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
    quo_fix  = quo_q;
    rem_fix  = rem_q[XLEN-1:0];
    if (!special_q) begin
      if (neg1_q ^ neg2_q) quo_fix = -quo_q;
      if (neg1_q)          rem_fix = -rem_q[XLEN-1:0];
    end
    fix_result = '0;
    unique case (func3_q)
      INST_MUL:                           fix_result = prod_fix[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:                fix_result = quo_fix;
      INST_REM, INST_REMU:                fix_result = rem_fix;
      default:                            fix_result = '0;
    endcase
  end

  // Stall while an op is accepted or running; a flush always releases the pipeline
  always_comb begin
    bus.hold_flag_o = 1'b0;
    if (!bus.flush_i) begin
      unique case (state_q)
        StIdle:         bus.hold_flag_o = bus.start_i;
        StCalc, StFix:  bus.hold_flag_o = 1'b1;
        StDone:         bus.hold_flag_o = 1'b0;
        default:        bus.hold_flag_o = 1'b0;
      endcase
    end
    bus.busy_o = (state_q != StIdle);
  end

  assign bus.reg_wen_o = wen_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.rd_data_o = rd_data_q;

  // FSM, datapath and registered writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      func3_q   <= '0;
      rd_q      <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      wen_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (bus.flush_i) begin
      state_q   <= StIdle;
      wen_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            func3_q   <= bus.func3_i;
            rd_q      <= bus.rd_addr_i;
            neg1_q    <= op1_neg;
            neg2_q    <= op2_neg;
            opb_q     <= op2_mag;
            cnt_q     <= '0;
            special_q <= div_zero | div_ovf;
            if (div_zero || div_ovf) begin
              quo_q   <= div_zero ? '1 : bus.op1_i;
              rem_q   <= div_zero ? {1'b0, bus.op1_i} : '0;
              acc_q   <= '0;
              state_q <= StFix;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, op1_mag};
              quo_q   <= op1_mag;
              rem_q   <= '0;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (func3_q[2]) begin
            rem_q <= step_rem;
            quo_q <= {quo_q[XLEN-2:0], step_bit};
          end else begin
            acc_q <= {mul_sum, acc_q[XLEN-1:1]};
          end
          if (cnt_q == LAST_CNT) state_q <= StFix;
        end
        StFix: begin
          rd_data_q <= fix_result;
          rd_addr_q <= rd_q;
          wen_q     <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          rd_data_q <= '0;
          rd_addr_q <= '0;
          wen_q     <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
